divider: RTL

- Iterative radix-2 restoring integer divider for the RV32M DIV/DIVU/REM/REMU path.
- It is the inverse-operation companion to the CPU's tree multiplier and uses the same start/done handshake, so the execute stage drives both units identically.
- It produces quotient and remainder together and applies the RISC-V divide-by-zero and signed-overflow rules internally.

---
 rtl/divider_if.sv | 24 ++
 rtl/divider.sv | 133 +++++++++++++
 2 files changed

// File: rtl/divider_if.sv
// Request/response bundle shared by the divider and the execute stage that drives it.
// Same start/done shape as the multiplier port, so both units are driven identically.
interface divider_if #(
   parameter int unsigned width = 32
);
   logic             start;
   logic             op_signed;
   logic [width-1:0] A;
   logic [width-1:0] B;
   logic [width-1:0] Q;
   logic [width-1:0] R;
   logic             done;
   logic             busy;

   modport master (
      output start, op_signed, A, B,
      input  Q, R, done, busy
   );

   modport slave (
      input  start, op_signed, A, B,
      output Q, R, done, busy
   );
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces quotient and remainder together, with RISC-V divide-by-zero and overflow results.
module divider #(
   parameter int unsigned width = 32
) (
   input  logic     clk,
   input  logic     rst,
   divider_if.slave bus
);
   localparam int unsigned CntW = $clog2(width);

   typedef enum logic [1:0] {StIdle, StDiv, StDone} state_e;

   state_e           state_q;
   logic             op_signed_q;
   logic             a_neg_q;
   logic             b_neg_q;
   logic             special_q;
   logic [width-1:0] dvd_q;
   logic [width-1:0] dvs_q;
   logic [width-1:0] rem_q;
   logic [width-1:0] q_q;
   logic [width-1:0] r_q;
   logic [CntW-1:0]  cnt_q;
   logic             done_q;
   logic             busy_q;

   logic             a_neg;
   logic             b_neg;
   logic             div_zero;
   logic             ovf;
   logic [width-1:0] abs_a;
   logic [width-1:0] abs_b;
   logic [width:0]   shifted;
   logic [width:0]   diff;
   logic [width-1:0] quo_nx;
   logic [width-1:0] rem_nx;
   logic [width-1:0] q_fix;
   logic [width-1:0] r_fix;

   always_comb begin
      a_neg    = bus.op_signed & bus.A[width-1];
      b_neg    = bus.op_signed & bus.B[width-1];
      abs_a    = a_neg ? -bus.A : bus.A;
      abs_b    = b_neg ? -bus.B : bus.B;
      div_zero = (bus.B == '0);
      ovf      = bus.op_signed && (bus.A == {1'b1, {(width-1){1'b0}}}) && (bus.B == '1);

      // rem < divisor always holds, so width+1 bits are enough and the MSB is the borrow
      shifted  = {rem_q, dvd_q[width-1]};
      diff     = shifted - {1'b0, dvs_q};
      quo_nx   = {dvd_q[width-2:0], ~diff[width]};
      rem_nx   = diff[width] ? shifted[width-1:0] : diff[width-1:0];

      q_fix    = (op_signed_q && (a_neg_q != b_neg_q)) ? -quo_nx : quo_nx;
      r_fix    = (op_signed_q && a_neg_q) ? -rem_nx : rem_nx;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         op_signed_q <= 1'b0;
         a_neg_q     <= 1'b0;
         b_neg_q     <= 1'b0;
         special_q   <= 1'b0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         q_q         <= '0;
         r_q         <= '0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (bus.start) begin
                  op_signed_q <= bus.op_signed;
                  a_neg_q     <= a_neg;
                  b_neg_q     <= b_neg;
                  cnt_q       <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= StDiv;
                  // Special results are parked in dvd/rem and copied out after one cycle
                  if (div_zero) begin
                     special_q <= 1'b1;
                     dvd_q     <= '1;
                     rem_q     <= bus.A;
                  end else if (ovf) begin
                     special_q <= 1'b1;
                     dvd_q     <= bus.A;
                     rem_q     <= '0;
                  end else begin
                     special_q <= 1'b0;
                     dvd_q     <= abs_a;
                     dvs_q     <= abs_b;
                     rem_q     <= '0;
                  end
               end
            end
            StDiv: begin
               if (special_q) begin
                  q_q     <= dvd_q;
                  r_q     <= rem_q;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end else begin
                  dvd_q <= quo_nx;
                  rem_q <= rem_nx;
                  cnt_q <= cnt_q + CntW'(1);
                  if (cnt_q == CntW'(width - 1)) begin
                     q_q     <= q_fix;
                     r_q     <= r_fix;
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.Q    = q_q;
   assign bus.R    = r_q;
   assign bus.done = done_q;
   assign bus.busy = busy_q;
endmodule
